aes_core_sched: RTL and testbench
=================================

AES_CORE_SCHED -- requirements
Module: aes_core_sched

Interface
REQ-001 Parameter MAX_OUT, default 8: maximum blocks in flight in the encrypt core plus blocks held in the result buffer (credit limit, 2..15).
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RSTB  input  1  asynchronous, active-low reset.
REQ-004 job_start  input  1  pulse; begin a job using key_len/op.
REQ-005 key_len  input  2  00 = 128-bit, 01 = 192-bit, 10 = 256-bit, 11 = invalid.
REQ-006 op_in  input  1  1 = encrypt, 0 = decrypt; sampled at job_start.
REQ-007 job_end  input  1  pulse; no further blocks for this job.
REQ-008 blk_valid / blk_ready  input / output  1 / 1  input-block handshake.
REQ-009 blk_data  input  128  plaintext or ciphertext block.
REQ-010 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-011 res_data  output  128  result block.
REQ-012 busy, done, err  output  1 each  job active; 1-cycle job-complete pulse; 1-cycle protocol-error pulse.
REQ-013 Plain_text  output  128;  t_ready  output  1;  t_reset  output  1;  op  output  1;  Nr  output  4  (encrypt-core side).
REQ-014 Core_Full, c_ready  input  1 each;  Ciphertext  input  128  (encrypt-core side).
REQ-015 k_ready, k_reset  output  1 each;  Nk_val  output  4;  k_done  input  1  (key-expansion side).

Function
REQ-016 FSM states: IDLE, KRST, KEXP, RUN, DRAIN; busy = 1 in every state except IDLE.
REQ-017 IDLE: job_start with key_len = 11 -> err pulse next cycle, stay in IDLE; job_start with a valid key_len -> KRST. job_start in any other state -> err pulse, ignored.
REQ-018 On entry to KRST, latch op, Nr (10/12/14), and Nk_val (4/6/8) from key_len; these hold until the next accepted job_start.
REQ-019 KRST: t_reset = 1 and k_reset = 1 for exactly one cycle -> KEXP.
REQ-020 KEXP: k_ready is held at 1 until k_done = 1 is sampled; k_ready falls in the same edge that moves the FSM to RUN.
REQ-021 blk_ready = (state == RUN) && !Core_Full && (outstanding + fifo_count < MAX_OUT); it is a combinational output.
REQ-022 Accept (blk_valid && blk_ready): next cycle Plain_text = blk_data (registered) and t_ready = 1 for exactly one cycle; outstanding += 1.
REQ-023 c_ready = 1 with outstanding > 0: push Ciphertext into the result FIFO; outstanding -= 1. Accept and c_ready in the same cycle leave outstanding unchanged.
REQ-024 c_ready = 1 with outstanding == 0: err pulse, data discarded, counters unchanged.
REQ-025 The credit rule guarantees the FIFO never overflows; the core is never back-pressured.
REQ-026 Result FIFO is first-in first-out, depth MAX_OUT. res_valid = !empty; res_data = head entry (first-word fall-through). Push and pop in the same cycle are both honoured, including when full or when holding 1 entry.
REQ-027 job_end in RUN -> DRAIN (blk_ready = 0 from the next cycle). An accept in the same cycle as job_end completes normally. job_end outside RUN -> ignored.
REQ-028 DRAIN: when outstanding == 0 and the FIFO is empty -> IDLE with a done pulse on that transition.
REQ-029 Block order is preserved end to end; the core's results are in order.

Reset
REQ-030 RSTB low: FSM = IDLE, outstanding = 0, FIFO empty.
REQ-031 Reset values: all 1-bit outputs = 0, Plain_text = 0, Nr = 0, Nk_val = 0, op = 0. A reset mid-job discards all in-flight and buffered data without a done pulse.

Structure
REQ-032 Shared package aes_sched_pkg holds:
- the state enum;
- key_len encodings;
- the Nr/Nk lookup constants (10/12/14, 4/6/8).
REQ-033 The result FIFO is a sub-module, sched_res_fifo (parameters WIDTH = 128, DEPTH = MAX_OUT, count output); all other logic is inline.

Verification
REQ-034 key_len = 01, op_in = 1, job_start; k_done asserted 5 cycles later -> t_reset/k_reset 1-cycle pulse, Nr = 12, Nk_val = 6, k_ready high for exactly 5 cycles, then RUN.
REQ-035 Core returns c_ready 3 cycles after each t_ready; 20 blocks sent back to back; res_ready = 1 -> 20 results in order, done pulse after the last pop, no err.
REQ-036 MAX_OUT = 8, res_ready = 0, core does not respond -> exactly 8 blocks accepted, then blk_ready = 0. After one pop, blk_ready = 1 again the next cycle.
REQ-037 Core_Full = 1 for 4 cycles in RUN -> no accept and no t_ready during those cycles; traffic resumes on the cycle after Core_Full drops.
REQ-038 c_ready with outstanding == 0 -> err pulse, FIFO count stays 0. key_len = 11 with job_start -> err pulse, FSM stays IDLE.
REQ-039 RSTB asserted with 3 blocks outstanding and 2 buffered -> all outputs return to their reset values immediately, res_valid = 0, no done pulse.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES core scheduler: FSM states,
// key length encodings and the round / key-word count lookups.
package aes_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KRST,
        ST_KEXP,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] KEY_128 = 2'b00;
    localparam logic [1:0] KEY_192 = 2'b01;
    localparam logic [1:0] KEY_256 = 2'b10;
    localparam logic [1:0] KEY_INV = 2'b11;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    // Round count for a key length; the invalid code never reaches here.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KEY_192: nr_of = NR_192;
            KEY_256: nr_of = NR_256;
            default: nr_of = NR_128;
        endcase
    endfunction

    // Key length in 32-bit words for a key length code.
    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KEY_192: nk_of = NK_192;
            KEY_256: nk_of = NK_256;
            default: nk_of = NK_128;
        endcase
    endfunction

endpackage

// File: rtl/sched_res_fifo.sv
// Result buffer: first-word fall-through FIFO with occupancy count.
// Push and pop in the same cycle are both taken, even when full.
module sched_res_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        nxt = (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= nxt(wr_ptr);
            if (rd_en) rd_ptr <= nxt(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; data is not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/aes_core_sched.sv
// AES core scheduler: sequences key expansion, feeds blocks to the
// encrypt core under a credit limit and buffers its results in order.
module aes_core_sched
    import aes_sched_pkg::*;
#(
    parameter int MAX_OUT = 8
) (
    input  logic         CLK,
    input  logic         RSTB,
    input  logic         job_start,
    input  logic [1:0]   key_len,
    input  logic         op_in,
    input  logic         job_end,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] Plain_text,
    output logic         t_ready,
    output logic         t_reset,
    output logic         op,
    output logic [3:0]   Nr,
    input  logic         Core_Full,
    input  logic         c_ready,
    input  logic [127:0] Ciphertext,
    output logic         k_ready,
    output logic         k_reset,
    output logic [3:0]   Nk_val,
    input  logic         k_done
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW:0] CREDIT = (CW + 1)'(MAX_OUT);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic          start_ok;
    logic          proto_err;
    logic          drain_exit;

    assign accept     = blk_valid && blk_ready;
    assign push       = c_ready && (outstanding != '0);
    assign pop        = res_valid && res_ready;
    assign start_ok   = job_start && (state == ST_IDLE) && (key_len != KEY_INV);
    assign proto_err  = (job_start && ((state != ST_IDLE) || (key_len == KEY_INV)))
                     || (c_ready && (outstanding == '0));
    assign drain_exit = (state == ST_DRAIN) && (outstanding == '0) && fifo_empty;
    assign res_valid  = !fifo_empty;
    assign blk_ready  = (state == ST_RUN) && !Core_Full
                     && (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDIT);

    // State register.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and state-decoded strobes.
    always_comb begin
        state_nxt = state;
        t_reset   = 1'b0;
        k_reset   = 1'b0;
        k_ready   = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_KRST;
            ST_KRST: begin
                t_reset   = 1'b1;
                k_reset   = 1'b1;
                state_nxt = ST_KEXP;
            end
            ST_KEXP: begin
                k_ready = 1'b1;
                if (k_done) state_nxt = ST_RUN;
            end
            ST_RUN:   if (job_end) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_exit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Job configuration, pulses and in-flight block count.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            op          <= 1'b0;
            Nr          <= '0;
            Nk_val      <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
            t_ready     <= 1'b0;
            outstanding <= '0;
        end else begin
            if (start_ok) begin
                op     <= op_in;
                Nr     <= nr_of(key_len);
                Nk_val <= nk_of(key_len);
            end
            err     <= proto_err;
            done    <= drain_exit;
            t_ready <= accept;
            case ({accept, push})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Block register toward the encrypt core.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)       Plain_text <= '0;
        else if (accept) Plain_text <= blk_data;
    end

    sched_res_fifo #(
        .WIDTH (128),
        .DEPTH (MAX_OUT)
    ) u_res_fifo (
        .clk   (CLK),
        .rstb  (RSTB),
        .push  (push),
        .din   (Ciphertext),
        .pop   (pop),
        .dout  (res_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_aes_core_sched.sv
// Directed bench for aes_core_sched with a small encrypt-core model.
module tb_aes_core_sched;

    localparam int MAX_OUT = 8;
    localparam logic [127:0] MASK = 128'h5A5A_A5A5_0F0F_F0F0_3C3C_C3C3_9696_6969;

    logic         CLK;
    logic         RSTB;
    logic         job_start;
    logic [1:0]   key_len;
    logic         op_in;
    logic         job_end;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] blk_data;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res_data;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] Plain_text;
    logic         t_ready;
    logic         t_reset;
    logic         op;
    logic [3:0]   Nr;
    logic         Core_Full;
    logic         c_ready;
    logic [127:0] Ciphertext;
    logic         k_ready;
    logic         k_reset;
    logic [3:0]   Nk_val;
    logic         k_done;

    logic         core_en;
    logic         man_c_ready;
    logic [127:0] man_ct;
    logic [2:0]   sr;
    logic [127:0] pd [3];
    logic [127:0] exp_q [$];

    int n_chk;
    int n_fail;
    int n_acc;
    int seq;
    int cyc_cnt;
    int err_cnt;
    int done_cnt;
    int done_cyc;
    int pop_cnt;
    int last_pop_cyc;

    aes_core_sched #(.MAX_OUT(MAX_OUT)) dut (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .job_start  (job_start),
        .key_len    (key_len),
        .op_in      (op_in),
        .job_end    (job_end),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .Plain_text (Plain_text),
        .t_ready    (t_ready),
        .t_reset    (t_reset),
        .op         (op),
        .Nr         (Nr),
        .Core_Full  (Core_Full),
        .c_ready    (c_ready),
        .Ciphertext (Ciphertext),
        .k_ready    (k_ready),
        .k_reset    (k_reset),
        .Nk_val     (Nk_val),
        .k_done     (k_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Encrypt-core model: answers each t_ready three cycles later with data ^ MASK.
    always @(posedge CLK) begin
        if (!RSTB) begin
            sr <= '0;
        end else begin
            sr    <= {sr[1:0], t_ready};
            pd[0] <= Plain_text;
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end
    assign c_ready    = core_en ? sr[2] : man_c_ready;
    assign Ciphertext = core_en ? (pd[2] ^ MASK) : man_ct;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] vec(input int n);
        vec = {32'h1111_0000 + 32'(n), 32'h2222_0000 + 32'(n),
               32'h3333_0000 + 32'(n), 32'h4444_0000 + 32'(n)};
    endfunction

    // Monitor: counts pulses and checks every result pop against the scoreboard.
    initial begin
        cyc_cnt = 0; err_cnt = 0; done_cnt = 0; done_cyc = 0;
        pop_cnt = 0; last_pop_cyc = 0;
        forever begin
            @(posedge CLK);
            cyc_cnt++;
            if (RSTB) begin
                if (err) err_cnt++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc_cnt;
                end
                if (res_valid && res_ready) begin
                    pop_cnt++;
                    last_pop_cyc = cyc_cnt;
                    if (exp_q.size() == 0) chk("res_unexpected", 128'd1, 128'd0);
                    else                   chk("res_data", res_data, exp_q.pop_front());
                end
            end
        end
    end

    // One clock: note an accept, step the edge, advance the block source.
    task automatic cyc();
        logic acc;
        #1;
        acc = blk_valid && blk_ready;
        if (acc) begin
            if (core_en) exp_q.push_back(blk_data ^ MASK);
            n_acc++;
        end
        @(posedge CLK);
        #1;
        if (acc) begin
            seq++;
            blk_data = vec(seq);
        end
    endtask

    task automatic start_job(input logic [1:0] kl, input logic o);
        key_len   = kl;
        op_in     = o;
        job_start = 1'b1;
        cyc();
        job_start = 1'b0;
        cyc();
        k_done = 1'b1;
        cyc();
        k_done = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int g;
        d0 = done_cnt;
        g  = 0;
        while (done_cnt == d0 && g < 300) begin
            cyc();
            g++;
        end
        chk(tag, 128'(done_cnt - d0), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int kcnt;
        int a0;
        int e0;
        int p0;
        int d0;
        int g;
        n_chk = 0; n_fail = 0; n_acc = 0; seq = 0;
        RSTB = 1'b0; job_start = 1'b0; key_len = 2'b00; op_in = 1'b0;
        job_end = 1'b0; blk_valid = 1'b0; blk_data = vec(0); res_ready = 1'b0;
        Core_Full = 1'b0; k_done = 1'b0; core_en = 1'b0; man_c_ready = 1'b0;
        man_ct = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_blk_ready", 128'(blk_ready), 128'd0);
        chk("rst_res_valid", 128'(res_valid), 128'd0);
        chk("rst_nr",        128'(Nr),        128'd0);
        chk("rst_nk",        128'(Nk_val),    128'd0);
        chk("rst_plain",     Plain_text,      128'd0);
        chk("rst_k_ready",   128'(k_ready),   128'd0);
        RSTB = 1'b1;
        cyc();

        // Key expansion sequencing with a 192-bit key.
        key_len = 2'b01; op_in = 1'b1; job_start = 1'b1;
        cyc();
        job_start = 1'b0;
        chk("krst_t_reset", 128'(t_reset), 128'd1);
        chk("krst_k_reset", 128'(k_reset), 128'd1);
        chk("krst_nr",      128'(Nr),      128'd12);
        chk("krst_nk",      128'(Nk_val),  128'd6);
        chk("krst_op",      128'(op),      128'd1);
        chk("krst_busy",    128'(busy),    128'd1);
        cyc();
        chk("kexp_t_reset", 128'(t_reset), 128'd0);
        chk("kexp_k_reset", 128'(k_reset), 128'd0);
        kcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (k_ready) kcnt++;
            k_done = (i == 4);
            cyc();
        end
        k_done = 1'b0;
        chk("k_ready_cycles", 128'(kcnt), 128'd5);
        chk("run_blk_ready",  128'(blk_ready), 128'd1);

        // Twenty back-to-back blocks through the core model.
        core_en = 1'b1; res_ready = 1'b1; blk_valid = 1'b1;
        a0 = n_acc; e0 = err_cnt; p0 = pop_cnt; g = 0;
        while ((n_acc - a0) < 20 && g < 200) begin
            cyc();
            g++;
        end
        blk_valid = 1'b0;
        chk("b2b_cycles", 128'(g), 128'd20);
        job_end = 1'b1;
        cyc();
        job_end = 1'b0;
        wait_done("stream_done");
        chk("stream_results", 128'(pop_cnt - p0), 128'd20);
        chk("stream_err",     128'(err_cnt - e0), 128'd0);
        chk("done_after_pop", 128'(done_cyc > last_pop_cyc), 128'd1);
        chk("stream_idle",    128'(busy), 128'd0);

        // Credit limit with a silent core and a stalled result port.
        core_en = 1'b0; res_ready = 1'b0;
        start_job(2'b00, 1'b1);
        chk("k128_nr", 128'(Nr),     128'd10);
        chk("k128_nk", 128'(Nk_val), 128'd4);
        a0 = n_acc;
        blk_valid = 1'b1;
        repeat (12) cyc();
        blk_valid = 1'b0;
        chk("credit_accepts",   128'(n_acc - a0), 128'd8);
        chk("credit_blk_ready", 128'(blk_ready),  128'd0);
        for (int i = 0; i < 8; i++) begin
            man_ct = vec(100 + i) ^ MASK;
            exp_q.push_back(man_ct);
            man_c_ready = 1'b1;
            cyc();
        end
        man_c_ready = 1'b0;
        chk("full_blk_ready", 128'(blk_ready), 128'd0);
        chk("full_res_valid", 128'(res_valid), 128'd1);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        chk("pop_reopens", 128'(blk_ready), 128'd1);
        res_ready = 1'b1; job_end = 1'b1;
        cyc();
        job_end = 1'b0;
        wait_done("credit_done");

        // Core_Full stall, then job_end together with an accepted block.
        core_en = 1'b1; res_ready = 1'b1;
        start_job(2'b10, 1'b0);
        chk("k256_nr", 128'(Nr),     128'd14);
        chk("k256_nk", 128'(Nk_val), 128'd8);
        chk("k256_op", 128'(op),     128'd0);
        blk_valid = 1'b1;
        cyc();
        cyc();
        Core_Full = 1'b1;
        a0 = n_acc;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_no_ready", 128'(blk_ready), 128'd0);
            cyc();
            chk("full_no_t_ready", 128'(t_ready), 128'd0);
        end
        Core_Full = 1'b0;
        chk("full_no_accept", 128'(n_acc - a0), 128'd0);
        #1;
        chk("resume_ready", 128'(blk_ready), 128'd1);
        cyc();
        chk("resume_t_ready", 128'(t_ready), 128'd1);
        a0 = n_acc;
        job_end = 1'b1;
        cyc();
        job_end = 1'b0; blk_valid = 1'b0;
        chk("end_accept", 128'(n_acc - a0), 128'd1);
        chk("drain_blk_ready", 128'(blk_ready), 128'd0);
        wait_done("full_done");
        chk("full_queue_empty", 128'(exp_q.size()), 128'd0);

        // Protocol errors in IDLE.
        core_en = 1'b0;
        man_c_ready = 1'b1; man_ct = vec(77);
        cyc();
        man_c_ready = 1'b0;
        chk("stray_c_err",   128'(err),       128'd1);
        chk("stray_c_empty", 128'(res_valid), 128'd0);
        cyc();
        chk("err_one_cycle", 128'(err), 128'd0);
        key_len = 2'b11; job_start = 1'b1;
        cyc();
        job_start = 1'b0;
        chk("bad_key_err",  128'(err),  128'd1);
        chk("bad_key_idle", 128'(busy), 128'd0);
        cyc();
        chk("bad_key_stay", 128'(busy), 128'd0);

        // Reset with three blocks in flight and two buffered.
        res_ready = 1'b0;
        start_job(2'b00, 1'b1);
        blk_valid = 1'b1;
        repeat (5) cyc();
        blk_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            man_ct = vec(200 + i);
            exp_q.push_back(man_ct);
            man_c_ready = 1'b1;
            cyc();
        end
        man_c_ready = 1'b0;
        chk("pre_rst_valid", 128'(res_valid), 128'd1);
        d0 = done_cnt;
        RSTB = 1'b0;
        #1;
        chk("mid_rst_busy",    128'(busy),      128'd0);
        chk("mid_rst_valid",   128'(res_valid), 128'd0);
        chk("mid_rst_plain",   Plain_text,      128'd0);
        chk("mid_rst_nr",      128'(Nr),        128'd0);
        chk("mid_rst_t_ready", 128'(t_ready),   128'd0);
        exp_q.delete();
        repeat (3) cyc();
        RSTB = 1'b1;
        cyc();
        chk("mid_rst_no_done", 128'(done_cnt - d0), 128'd0);
        chk("post_rst_valid",  128'(res_valid),     128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
